// File: rtl/rf_access_arbiter.sv
// ============================================================================
// Module : rf_access_arbiter
// Brief  : Shares the register-file write port and debug read port between
//          core writeback and a debug master. Optional RF_ACCESS_STATS_EN
//          adds grant/stall counters (ports are always present).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_access_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            core_we,
  input  logic [AW-1:0]   core_waddr,
  input  logic [XLEN-1:0] core_wdata,
  output logic            core_stall,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [AW-1:0]   rf_dbg_raddr,
  input  logic [XLEN-1:0] rf_dbg_rdata,
  output logic [15:0]     stat_grants,
  output logic [15:0]     stat_stalls
);

  localparam int c_cw = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_cw-1:0] c_starve = c_cw'(STARVE_MAX);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_pend    = 2'd1;
  localparam logic [1:0] c_ack     = 2'd2;
  localparam logic [1:0] c_release = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [c_cw-1:0] r_wait_cnt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;

  logic            w_dbg_slot;
  logic            w_stall;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rd_value;

  // A same-cycle core write to the read address wins over the stale RF value.
  assign w_rd_value = (r_addr == '0) ? '0 :
                      (core_we && (core_waddr == r_addr)) ? core_wdata : rf_dbg_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:    if (dbg_req) w_next = c_pend;
      c_pend:    if (!r_we || !core_we || (r_wait_cnt == c_starve)) w_next = c_ack;
      c_ack:     w_next = c_release;
      c_release: if (!dbg_req) w_next = c_idle;
      default:   w_next = c_idle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (dbg_req) begin
            r_we       <= dbg_we;
            r_addr     <= dbg_addr;
            r_wdata    <= dbg_wdata;
            r_wait_cnt <= '0;
          end
        end
        c_pend: begin
          if (!r_we) begin
            r_rdata <= w_rd_value;
          end else if (core_we && (r_wait_cnt != c_starve)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_dbg_slot = 1'b0;
    w_stall    = 1'b0;
    if ((r_state == c_pend) && r_we) begin
      if (!core_we) begin
        w_dbg_slot = 1'b1;
      end else if (r_wait_cnt == c_starve) begin
        w_dbg_slot = 1'b1;
        w_stall    = 1'b1;
      end
    end
    w_we    = w_dbg_slot ? 1'b1    : core_we;
    w_waddr = w_dbg_slot ? r_addr  : core_waddr;
    w_wdata = w_dbg_slot ? r_wdata : core_wdata;
    // The pass-through path is forced quiet while reset is held.
    rf_we        = !reset && w_we && (w_waddr != '0);
    rf_waddr     = reset ? '0 : w_waddr;
    rf_wdata     = reset ? '0 : w_wdata;
    rf_dbg_raddr = r_addr;
    core_stall   = w_stall;
    dbg_ack      = (r_state == c_ack);
    dbg_rdata    = r_rdata;
  end

`ifdef RF_ACCESS_STATS_EN
  logic [15:0] r_stat_grants;
  logic [15:0] r_stat_stalls;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_grants <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (dbg_ack && (r_stat_grants != 16'hFFFF)) r_stat_grants <= r_stat_grants + 16'd1;
      if (w_stall && (r_stat_stalls != 16'hFFFF)) r_stat_stalls <= r_stat_stalls + 16'd1;
    end
  end

  assign stat_grants = r_stat_grants;
  assign stat_stalls = r_stat_stalls;
`else
  assign stat_grants = 16'h0000;
  assign stat_stalls = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_access_arbiter.sv
// ============================================================================
// Module : tb_rf_access_arbiter
// Brief  : Transaction-level reference bench for rf_access_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_access_arbiter;

  localparam int XLEN       = 32;
  localparam int AW         = 5;
  localparam int STARVE_MAX = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            core_we;
  logic [AW-1:0]   core_waddr;
  logic [XLEN-1:0] core_wdata;
  logic            core_stall;
  logic            dbg_req;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_rdata;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   rf_dbg_raddr;
  logic [XLEN-1:0] rf_dbg_rdata;
  logic [15:0]     stat_grants;
  logic [15:0]     stat_stalls;

  logic [XLEN-1:0] mem [32];

  int              n_cmp = 0;
  int              n_err = 0;
  logic [XLEN-1:0] m_rdata = '0;
  int              m_grants = 0;
  int              m_stalls = 0;

  always #5 clock = ~clock;

  assign rf_dbg_rdata = mem[rf_dbg_raddr];

  rf_access_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_dbg_raddr(rf_dbg_raddr), .rf_dbg_rdata(rf_dbg_rdata),
    .stat_grants(stat_grants), .stat_stalls(stat_stalls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core behaviour: 0 random, 1 always writes the debug address,
  // 2 never writes, 3 always writes a nonzero random address.
  task automatic drive_core(input int mode, input logic [AW-1:0] a);
    core_wdata = $urandom;
    case (mode)
      0: begin core_we = 1'($urandom_range(0, 1)); core_waddr = 5'($urandom); end
      1: begin core_we = 1'b1; core_waddr = a; end
      2: begin core_we = 1'b0; core_waddr = 5'($urandom); end
      default: begin core_we = 1'b1; core_waddr = 5'($urandom_range(1, 31)); end
    endcase
  endtask

  task automatic scramble_dbg();
    dbg_we    = 1'($urandom);
    dbg_addr  = 5'($urandom);
    dbg_wdata = $urandom;
  endtask

  task automatic chk_cycle(input string tag, input bit slot, input logic [AW-1:0] a,
                           input logic [XLEN-1:0] d, input bit e_stall, input bit e_ack);
    logic            e_we;
    logic [AW-1:0]   e_addr;
    logic [XLEN-1:0] e_data;
    if (slot) begin
      e_addr = a; e_data = d; e_we = (a != 0);
    end else begin
      e_addr = core_waddr; e_data = core_wdata; e_we = core_we && (core_waddr != 0);
    end
    chk({tag, ".rf_we"},      32'(rf_we),      32'(e_we));
    chk({tag, ".rf_waddr"},   32'(rf_waddr),   32'(e_addr));
    chk({tag, ".rf_wdata"},   rf_wdata,        e_data);
    chk({tag, ".core_stall"}, 32'(core_stall), 32'(e_stall));
    chk({tag, ".dbg_ack"},    32'(dbg_ack),    32'(e_ack));
    chk({tag, ".dbg_rdata"},  dbg_rdata,       m_rdata);
`ifdef RF_ACCESS_STATS_EN
    chk({tag, ".grants"}, 32'(stat_grants), 32'(m_grants));
    chk({tag, ".stalls"}, 32'(stat_stalls), 32'(m_stalls));
`else
    chk({tag, ".grants"}, 32'(stat_grants), 32'd0);
    chk({tag, ".stalls"}, 32'(stat_stalls), 32'd0);
`endif
    if (e_ack)   m_grants++;
    if (e_stall) m_stalls++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rf_we"},        32'(rf_we),        32'd0);
    chk({tag, ".rf_waddr"},     32'(rf_waddr),     32'd0);
    chk({tag, ".rf_wdata"},     rf_wdata,          32'd0);
    chk({tag, ".rf_dbg_raddr"}, 32'(rf_dbg_raddr), 32'd0);
    chk({tag, ".core_stall"},   32'(core_stall),   32'd0);
    chk({tag, ".dbg_ack"},      32'(dbg_ack),      32'd0);
    chk({tag, ".dbg_rdata"},    dbg_rdata,         32'd0);
    chk({tag, ".grants"},       32'(stat_grants),  32'd0);
    chk({tag, ".stalls"},       32'(stat_stalls),  32'd0);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clock);
    dbg_req = 1'b0;
    drive_core(0, '0);
    #1 chk_cycle(tag, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // One full debug transaction: request, service, ack, then hold req for
  // 'hold' extra cycles before dropping it.
  task automatic txn(input string tag, input bit we, input logic [AW-1:0] a,
                     input logic [XLEN-1:0] d, input int mode, input int hold);
    logic [XLEN-1:0] er;
    bit              blocked;
    bit              done;
    int              k;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [XLEN-1:0] s_data;
    er = '0; blocked = 1'b0; done = 1'b0; k = 0;
    s_we = 1'b0; s_addr = '0; s_data = '0;

    @(negedge clock);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    drive_core(mode, a);
    #1 chk_cycle({tag, ".req"}, 1'b0, a, d, 1'b0, 1'b0);

    if (!we) begin
      @(negedge clock);
      scramble_dbg();
      drive_core(mode, a);
      #1;
      if (a == 0)                            er = '0;
      else if (core_we && core_waddr == a)   er = core_wdata;
      else                                   er = mem[a];
      chk({tag, ".raddr"}, 32'(rf_dbg_raddr), 32'(a));
      chk_cycle({tag, ".pend_rd"}, 1'b0, a, d, 1'b0, 1'b0);
    end else begin
      while (!done) begin
        @(negedge clock);
        scramble_dbg();
        drive_core(mode, a);
        #1;
        if (!core_we) begin
          chk_cycle({tag, ".pend_free"}, 1'b1, a, d, 1'b0, 1'b0);
          done = 1'b1;
        end else if (k < STARVE_MAX) begin
          chk_cycle({tag, ".pend_wait"}, 1'b0, a, d, 1'b0, 1'b0);
          k++;
        end else begin
          chk_cycle({tag, ".pend_stall"}, 1'b1, a, d, 1'b1, 1'b0);
          blocked = 1'b1;
          s_we = core_we; s_addr = core_waddr; s_data = core_wdata;
          done = 1'b1;
        end
      end
    end

    @(negedge clock);
    scramble_dbg();
    if (blocked) begin
      core_we = s_we; core_waddr = s_addr; core_wdata = s_data;
    end else begin
      drive_core(mode, a);
    end
    if (!we) m_rdata = er;
    #1 chk_cycle({tag, ".ack"}, 1'b0, a, d, 1'b0, 1'b1);

    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      dbg_req = 1'b1;
      drive_core(mode, a);
      #1 chk_cycle({tag, ".hold"}, 1'b0, a, d, 1'b0, 1'b0);
    end
    @(negedge clock);
    dbg_req = 1'b0;
    drive_core(mode, a);
    #1 chk_cycle({tag, ".drop"}, 1'b0, a, d, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    reset = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'hDEAD_BEEF;
    #2 chk_reset_vals("por");
    @(negedge clock);
    reset = 1'b0;
    idle_cycle("idle0");

    txn("wr_x5",     1'b1, 5'd5, 32'h19,        2, 0);
    txn("wr_starve", 1'b1, 5'd2, 32'hAB,        3, 0);
    txn("rd_bypass", 1'b0, 5'd2, 32'h0,         1, 0);
    txn("wr_x0",     1'b1, 5'd0, 32'hFFFF_FFFF, 2, 0);
    txn("rd_x0",     1'b0, 5'd0, 32'h0,         1, 0);
    txn("rd_x7",     1'b0, 5'd7, 32'h0,         2, 0);
    txn("hold3",     1'b1, 5'd9, 32'h1234_5678, 0, 3);

    // Reset while a write is pending under core pressure.
    @(negedge clock);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h5555_AAAA;
    drive_core(3, '0);
    #1 chk_cycle("rst.req", 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    drive_core(3, '0);
    #1 chk_cycle("rst.pend", 1'b0, '0, '0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 chk_reset_vals("rst.mid");
    dbg_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_rdata = '0; m_grants = 0; m_stalls = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive_core(2, '0);
      #1 chk_cycle("rst.after", 1'b0, '0, '0, 1'b0, 1'b0);
    end

    for (int t = 0; t < 40; t++) begin
      txn("rnd", 1'($urandom), 5'($urandom), $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle("gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Shares the register file write port and a dedicated debug read port between the risc_v core writeback path and an external debug/test access master.
- Used for bench preload and inspection of regFile contents, for example reading x2 after a program ends.
- Sits between the core datapath writeback and the register file.
- Core writeback has priority; debug requests are serviced in idle write slots, or by a forced one-cycle core stall after a starvation limit.

Parameters:
- XLEN, 32, data width
- AW, 5, register address width
- STARVE_MAX, 4, number of core-occupied cycles a pending debug write waits before a stall is forced (≥1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- core_we  in  1  core writeback enable
- core_waddr  in  AW  core writeback address
- core_wdata  in  XLEN  core writeback data
- core_stall  out  1  freeze core (PC and writeback held) this cycle
- dbg_req  in  1  debug request level; held with fields stable until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  AW  debug register address
- dbg_wdata  in  XLEN  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  XLEN  read result, valid while dbg_ack=1 and held until the next ack
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  XLEN  register file write data
- rf_dbg_raddr  out  AW  register file debug read address
- rf_dbg_rdata  in  XLEN  register file debug read data (combinational)

Behaviour:
- Reset (asynchronous, active-high) values:
  - state=IDLE, wait_cnt=0.
  - dbg_ack=0, dbg_rdata=0, core_stall=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_dbg_raddr=0.
- Reset mid-operation abandons any request: no ack and no write.
- FSM states: IDLE, PEND, ACK, RELEASE.
- IDLE:
  - Write port passes the core through: rf_we=core_we, rf_waddr=core_waddr, rf_wdata=core_wdata.
  - dbg_req=1 latches the request (we, addr, wdata), sets wait_cnt=0 and moves to PEND next cycle.
- PEND, read (dbg_we=0):
  - rf_dbg_raddr=dbg_addr; completes in this first PEND cycle.
  - dbg_rdata captures rf_dbg_rdata at the edge.
  - Bypass: if core_we=1 and core_waddr==dbg_addr≠0, capture core_wdata instead.
  - Address 0 always returns 0.
  - Next state ACK. Core is never stalled for a read.
- PEND, write (dbg_we=1):
  - If core_we=0: drive rf_we=1 with debug addr/data; next state ACK.
  - Else if wait_cnt<STARVE_MAX: core write proceeds and wait_cnt increments.
  - Else (wait_cnt==STARVE_MAX): core_stall=1 combinationally and the core write is blocked this cycle (core re-presents it next cycle). The debug write is issued; next state ACK.
  - Worst-case debug write latency is STARVE_MAX+1 cycles in PEND.
- ACK:
  - dbg_ack=1 for exactly one cycle; core passes through.
  - Next state RELEASE.
- RELEASE:
  - Core passes through; waits for dbg_req=0, then goes to IDLE.
  - A request held high across ack is not re-serviced.
- x0 suppression: any write to address 0 from either source gives rf_we=0. A debug write to x0 still completes and acks normally.
- core_stall is asserted only in PEND write at the starvation limit, for exactly one cycle per request.
- Field changes on dbg_* while in PEND/ACK are ignored (latched copy used).

Optional Feature:
- Macro: RF_ACCESS_STATS_EN.
- When defined, adds outputs stat_grants[15:0] and stat_stalls[15:0]:
  - stat_grants counts debug acks.
  - stat_stalls counts cycles with core_stall=1.
  - Both saturate at 16'hFFFF and are cleared by reset.
- When not defined, the ports are still present and tied to 16'h0000, with no counter logic.

Test Plan:
- Reset then dbg write x5=0x19 with core_we=0 → rf_we=1, rf_waddr=5, rf_wdata=0x19 in the first PEND cycle; dbg_ack 1 cycle later; core_stall never 1.
- Core writes every cycle, dbg write x2=0xAB, STARVE_MAX=4 → 4 core writes pass; 5th PEND cycle core_stall=1 and rf writes x2=0xAB; the blocked core write lands the following cycle.
- Dbg read x2 while core writes x2=0x19 the same cycle → dbg_rdata=0x19 (bypass) at ack; no stall.
- Dbg write x0=0xFFFF_FFFF then dbg read x0 → rf_we stays 0; both ack; read data 0.
- dbg_req held high 3 cycles past ack → exactly one ack; a new request is accepted only after dbg_req drops.
- Assert reset in PEND with core_we=1 and a pending write → outputs return to reset values immediately, no ack, no debug write; with RF_ACCESS_STATS_EN the counters read 0.
